// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared definitions for the SDRAM slot arbiter:
// FSM state encodings and the slot-index width helper.
package jtframe_sdram_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtframe_arb_pick.sv
// Combinational slot picker: fixed priority for masked slots,
// rotating search from rr_ptr for the rest.
module jtframe_arb_pick
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int SLOTS = 10,
    parameter int SW    = 4
) (
    input  logic [SLOTS-1:0] pending,
    input  logic [SLOTS-1:0] prio_mask,
    input  logic [SW-1:0]    rr_ptr,
    output logic [SW-1:0]    sel,
    output logic             any
);

    // rr_ptr is always below SLOTS, so one wrap subtraction suffices
    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= SLOTS) s = s - SLOTS;
        return SW'(s);
    endfunction

    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!any && pending[i] && prio_mask[i]) begin
                sel = SW'(i);
                any = 1'b1;
            end
        end
        for (int k = 0; k < SLOTS; k++) begin
            if (!any && pending[wrap_idx(rr_ptr, k)] && !prio_mask[wrap_idx(rr_ptr, k)]) begin
                sel = wrap_idx(rr_ptr, k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// N-slot SDRAM request arbiter with per-slot last-address cache,
// optional per-slot writes and mixed priority/round-robin scheduling.
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int              SLOTS     = 10,
    parameter int              AW        = 22,
    parameter int              DW        = 32,
    parameter logic [SLOTS-1:0] PRIO_MASK = '0,
    parameter logic [SLOTS-1:0] WR_MASK   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS-1:0]    slot_wr,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS*16-1:0] slot_din,
    input  logic [SLOTS*2-1:0]  slot_dsn,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic [SLOTS-1:0]    slot_ok,
    input  logic                downloading,
    output logic                sdram_req,
    input  logic                sdram_ack,
    output logic [AW-1:0]       sdram_addr,
    output logic                sdram_rnw,
    output logic [15:0]         data_write,
    output logic [1:0]          sdram_wrmask,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    localparam int SW = idx_w(SLOTS);

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    rr_q, rr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             rnw_q, rnw_d;
    logic [15:0]      din_q, din_d;
    logic [1:0]       dsn_q, dsn_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [SLOTS-1:0] tag_wr_q, tag_wr_d;
    logic [AW-1:0]    tag_addr_q [SLOTS];
    logic [AW-1:0]    tag_addr_d [SLOTS];
    logic [DW-1:0]    dout_q [SLOTS];
    logic [DW-1:0]    dout_d [SLOTS];

    logic [SLOTS-1:0] eff_wr;
    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] inflight;
    logic [SLOTS-1:0] pending;
    logic [SW-1:0]    pick_sel;
    logic             pick_any;
    logic             done;

    assign eff_wr = slot_wr & WR_MASK;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign inflight[i] = (state_q != ST_IDLE) && (sel_q == SW'(i));
        assign hit[i] = valid_q[i] & slot_cs[i]
                      & (tag_addr_q[i] == slot_addr[i*AW +: AW])
                      & (tag_wr_q[i] == eff_wr[i]);
        assign slot_dout[i*DW +: DW] = dout_q[i];
    end

    assign pending = slot_cs & ~hit & ~inflight;

    jtframe_arb_pick #(
        .SLOTS (SLOTS),
        .SW    (SW)
    ) u_pick (
        .pending   (pending),
        .prio_mask (PRIO_MASK),
        .rr_ptr    (rr_q),
        .sel       (pick_sel),
        .any       (pick_any)
    );

    // an ack together with data_rdy finishes the access in the REQ cycle
    assign done = ((state_q == ST_REQ) && sdram_ack && data_rdy)
               || ((state_q == ST_WAIT) && data_rdy);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        rnw_d      = rnw_q;
        din_d      = din_q;
        dsn_d      = dsn_q;
        valid_d    = downloading ? '0 : valid_q;
        tag_wr_d   = tag_wr_q;
        tag_addr_d = tag_addr_q;
        dout_d     = dout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any && !downloading) begin
                    sel_d   = pick_sel;
                    addr_d  = slot_addr[int'(pick_sel)*AW +: AW];
                    rnw_d   = !eff_wr[pick_sel];
                    din_d   = slot_din[int'(pick_sel)*16 +: 16];
                    dsn_d   = slot_dsn[int'(pick_sel)*2 +: 2];
                    state_d = ST_REQ;
                    if (!PRIO_MASK[pick_sel])
                        rr_d = (int'(pick_sel) == SLOTS-1) ? '0 : pick_sel + SW'(1);
                end
            end
            ST_REQ: begin
                if (sdram_ack) state_d = data_rdy ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (data_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (done) begin
            if (rnw_q) dout_d[sel_q] = data_read;
            tag_addr_d[sel_q] = addr_q;
            tag_wr_d[sel_q]   = !rnw_q;
            if (!downloading) valid_d[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rr_q       <= '0;
            addr_q     <= '0;
            rnw_q      <= 1'b1;
            din_q      <= '0;
            dsn_q      <= 2'b11;
            valid_q    <= '0;
            tag_wr_q   <= '0;
            tag_addr_q <= '{default: '0};
            dout_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            rnw_q      <= rnw_d;
            din_q      <= din_d;
            dsn_q      <= dsn_d;
            valid_q    <= valid_d;
            tag_wr_q   <= tag_wr_d;
            tag_addr_q <= tag_addr_d;
            dout_q     <= dout_d;
        end
    end

    assign slot_ok      = hit;
    assign sdram_req    = (state_q == ST_REQ);
    assign sdram_addr   = addr_q;
    assign sdram_rnw    = rnw_q;
    assign data_write   = din_q;
    assign sdram_wrmask = dsn_q;
    assign refresh_en   = (state_q == ST_IDLE) && (pending == '0);

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed bench for jtframe_sdram_arb: table of single reads plus
// hand sequences for hits, writes, arbitration, download and reset.
module tb_jtframe_sdram_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [SLOTS-1:0]    slot_cs = '0;
    logic [SLOTS-1:0]    slot_wr = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS*16-1:0] slot_din = '0;
    logic [SLOTS*2-1:0]  slot_dsn = '1;
    logic [SLOTS*DW-1:0] slot_dout;
    logic [SLOTS-1:0]    slot_ok;
    logic                downloading = 1'b0;
    logic                sdram_req;
    logic                sdram_ack = 1'b0;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_rnw;
    logic [15:0]         data_write;
    logic [1:0]          sdram_wrmask;
    logic                data_rdy = 1'b0;
    logic [DW-1:0]       data_read = '0;
    logic                refresh_en;

    int n_vec = 0;
    int n_bad = 0;

    logic [AW-1:0] cap_addr;
    logic          cap_rnw;
    logic [15:0]   cap_wd;
    logic [1:0]    cap_wm;
    int            cap_wait;

    typedef struct {
        int          slot;
        logic [21:0] addr;
        int          ack_dly;
        int          rdy_dly;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [4];

    jtframe_sdram_arb #(
        .SLOTS     (SLOTS),
        .AW        (AW),
        .DW        (DW),
        .PRIO_MASK (4'b0001),
        .WR_MASK   (4'b0010)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .slot_cs      (slot_cs),
        .slot_wr      (slot_wr),
        .slot_addr    (slot_addr),
        .slot_din     (slot_din),
        .slot_dsn     (slot_dsn),
        .slot_dout    (slot_dout),
        .slot_ok      (slot_ok),
        .downloading  (downloading),
        .sdram_req    (sdram_req),
        .sdram_ack    (sdram_ack),
        .sdram_addr   (sdram_addr),
        .sdram_rnw    (sdram_rnw),
        .data_write   (data_write),
        .sdram_wrmask (sdram_wrmask),
        .data_rdy     (data_rdy),
        .data_read    (data_read),
        .refresh_en   (refresh_en)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic cs, input logic wr,
                         input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        slot_cs[s]             = cs;
        slot_wr[s]             = wr;
        slot_addr[s*AW +: AW]  = a;
        slot_din[s*16 +: 16]   = d;
        slot_dsn[s*2 +: 2]     = m;
    endtask

    function automatic logic [DW-1:0] dout_of(input int s);
        return slot_dout[s*DW +: DW];
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, 64'(sdram_req), 64'(0));
        chk({tag, "_ok"}, 64'(slot_ok), 64'(0));
        chk({tag, "_dout"}, 64'(|slot_dout), 64'(0));
        chk({tag, "_addr"}, 64'(sdram_addr), 64'(0));
        chk({tag, "_rnw"}, 64'(sdram_rnw), 64'(1));
        chk({tag, "_wdata"}, 64'(data_write), 64'(0));
        chk({tag, "_wmask"}, 64'(sdram_wrmask), 64'(2'b11));
        chk({tag, "_refresh"}, 64'(refresh_en), 64'(1));
    endtask

    // Controller model: called at a sample point; waits for req, acks in
    // req cycle ack_dly, returns data rdy_dly cycles after the ack.
    task automatic serve(input int ack_dly, input int rdy_dly, input logic [31:0] d);
        int n;
        n = 0;
        while (!sdram_req && n < 16) begin
            nxt();
            mid();
            n++;
        end
        cap_wait = n;
        if (!sdram_req) begin
            chk("req_timeout", 64'(sdram_req), 64'(1));
            return;
        end
        cap_addr = sdram_addr;
        cap_rnw  = sdram_rnw;
        cap_wd   = data_write;
        cap_wm   = sdram_wrmask;
        for (int k = 1; k < ack_dly; k++) begin
            nxt();
            mid();
            chk("req_hold", 64'(sdram_req), 64'(1));
            chk("addr_stable", 64'(sdram_addr), 64'(cap_addr));
        end
        sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            data_rdy  = 1'b1;
            data_read = d;
        end
        nxt();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        for (int j = 1; j <= rdy_dly; j++) begin
            mid();
            chk("req_drop", 64'(sdram_req), 64'(0));
            chk("wait_stable", 64'({sdram_addr, sdram_rnw, data_write, sdram_wrmask}),
                64'({cap_addr, cap_rnw, cap_wd, cap_wm}));
            if (j == rdy_dly) begin
                data_rdy  = 1'b1;
                data_read = d;
            end
            nxt();
            data_rdy = 1'b0;
        end
        mid();
        chk("req_idle", 64'(sdram_req), 64'(0));
    endtask

    initial begin
        tbl[0] = '{slot: 2, addr: 22'h001234, ack_dly: 2, rdy_dly: 3, data: 32'hCAFEBABE};
        tbl[1] = '{slot: 0, addr: 22'h0000AA, ack_dly: 1, rdy_dly: 1, data: 32'h11112222};
        tbl[2] = '{slot: 3, addr: 22'h3FFFFF, ack_dly: 3, rdy_dly: 0, data: 32'hDEADBEEF};
        tbl[3] = '{slot: 1, addr: 22'h000100, ack_dly: 1, rdy_dly: 2, data: 32'h0BADF00D};

        rst = 1'b1;
        nxt();
        nxt();
        mid();
        check_reset("rst0");
        nxt();
        rst = 1'b0;
        mid();

        for (int i = 0; i < 4; i++) begin
            nxt();
            drive(tbl[i].slot, 1'b1, 1'b0, tbl[i].addr, 16'h0, 2'b11);
            mid();
            chk("v_t0_req", 64'(sdram_req), 64'(0));
            chk("v_t0_ok", 64'(slot_ok[tbl[i].slot]), 64'(0));
            nxt();
            mid();
            chk("v_t1_req", 64'(sdram_req), 64'(1));
            serve(tbl[i].ack_dly, tbl[i].rdy_dly, tbl[i].data);
            chk("v_addr", 64'(cap_addr), 64'(tbl[i].addr));
            chk("v_rnw", 64'(cap_rnw), 64'(1));
            chk("v_ok", 64'(slot_ok[tbl[i].slot]), 64'(1));
            chk("v_dout", 64'(dout_of(tbl[i].slot)), 64'(tbl[i].data));
            nxt();
            slot_cs[tbl[i].slot] = 1'b0;
            mid();
            chk("v_ok_drop", 64'(slot_ok[tbl[i].slot]), 64'(0));
        end

        // Cache hit, then address change forces a miss
        nxt();
        drive(2, 1'b1, 1'b0, 22'h001234, 16'h0, 2'b11);
        mid();
        chk("hit_ok", 64'(slot_ok[2]), 64'(1));
        chk("hit_dout", 64'(dout_of(2)), 64'(32'hCAFEBABE));
        nxt();
        mid();
        chk("hit_noreq", 64'(sdram_req), 64'(0));
        nxt();
        drive(2, 1'b1, 1'b0, 22'h001235, 16'h0, 2'b11);
        mid();
        chk("miss_ok_drop", 64'(slot_ok[2]), 64'(0));
        nxt();
        mid();
        chk("miss_req", 64'(sdram_req), 64'(1));
        serve(1, 1, 32'h12351235);
        chk("miss_addr", 64'(cap_addr), 64'(22'h001235));
        chk("miss_dout", 64'(dout_of(2)), 64'(32'h12351235));
        nxt();
        slot_cs = '0;

        // Write on a write-capable slot, then read-back misses
        drive(1, 1'b1, 1'b1, 22'h002000, 16'h55AA, 2'b01);
        mid();
        serve(2, 1, 32'hFFFF0000);
        chk("wr_rnw", 64'(cap_rnw), 64'(0));
        chk("wr_data", 64'(cap_wd), 64'(16'h55AA));
        chk("wr_mask", 64'(cap_wm), 64'(2'b01));
        chk("wr_ok", 64'(slot_ok[1]), 64'(1));
        chk("wr_keeps_dout", 64'(dout_of(1)), 64'(32'h0BADF00D));
        nxt();
        slot_wr[1] = 1'b0;
        mid();
        chk("wr_rd_miss", 64'(slot_ok[1]), 64'(0));
        serve(1, 1, 32'h77778888);
        chk("wr_rd_rnw", 64'(cap_rnw), 64'(1));
        chk("wr_rd_dout", 64'(dout_of(1)), 64'(32'h77778888));
        nxt();
        slot_cs = '0;

        // Write request on a read-only slot is a read: hits the cached read
        drive(3, 1'b1, 1'b1, 22'h3FFFFF, 16'h1234, 2'b00);
        mid();
        chk("ro_wr_hit", 64'(slot_ok[3]), 64'(1));
        nxt();
        mid();
        chk("ro_wr_noreq", 64'(sdram_req), 64'(0));
        nxt();
        slot_cs = '0;
        slot_wr = '0;

        // Reset again so rr_ptr starts at 0 for arbitration
        rst = 1'b1;
        nxt();
        mid();
        check_reset("rst1");
        nxt();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 22'h000100, 16'h0, 2'b11);
        drive(1, 1'b1, 1'b0, 22'h000101, 16'h0, 2'b11);
        drive(3, 1'b1, 1'b0, 22'h000103, 16'h0, 2'b11);
        mid();
        chk("arb_refresh_off", 64'(refresh_en), 64'(0));
        serve(1, 1, 32'hA0A0A0A0);
        chk("arb_first", 64'(cap_addr), 64'(22'h000100));
        serve(1, 1, 32'hA1A1A1A1);
        chk("arb_second", 64'(cap_addr), 64'(22'h000101));
        chk("arb_b2b", 64'(cap_wait), 64'(1));
        drive(1, 1'b1, 1'b0, 22'h000111, 16'h0, 2'b11);
        serve(1, 1, 32'hA3A3A3A3);
        chk("arb_third", 64'(cap_addr), 64'(22'h000103));
        serve(1, 1, 32'hA5A5A5A5);
        chk("arb_fourth", 64'(cap_addr), 64'(22'h000111));
        chk("arb_all_ok", 64'(slot_ok), 64'(4'b1011));
        chk("arb_dout1", 64'(dout_of(1)), 64'(32'hA5A5A5A5));
        nxt();
        slot_cs = '0;
        mid();

        // Download starts while an access is waiting for data
        nxt();
        drive(2, 1'b1, 1'b0, 22'h004444, 16'h0, 2'b11);
        mid();
        nxt();
        mid();
        chk("dl_req", 64'(sdram_req), 64'(1));
        sdram_ack = 1'b1;
        nxt();
        sdram_ack   = 1'b0;
        downloading = 1'b1;
        mid();
        chk("dl_wait", 64'(sdram_req), 64'(0));
        data_rdy  = 1'b1;
        data_read = 32'h99999999;
        nxt();
        data_rdy = 1'b0;
        mid();
        chk("dl_ok", 64'(slot_ok), 64'(0));
        for (int k = 0; k < 3; k++) begin
            nxt();
            mid();
            chk("dl_noreq", 64'(sdram_req), 64'(0));
        end
        nxt();
        slot_cs = '0;
        mid();
        chk("dl_refresh", 64'(refresh_en), 64'(1));
        nxt();
        downloading = 1'b0;
        drive(0, 1'b1, 1'b0, 22'h000100, 16'h0, 2'b11);
        mid();
        chk("dl_clears_valid", 64'(slot_ok[0]), 64'(0));
        serve(1, 2, 32'hABCD0123);
        chk("dl_after_addr", 64'(cap_addr), 64'(22'h000100));
        chk("dl_after_dout", 64'(dout_of(0)), 64'(32'hABCD0123));
        nxt();
        slot_cs = '0;

        // Reset while waiting for data; a late data_rdy must be ignored
        drive(1, 1'b1, 1'b0, 22'h005555, 16'h0, 2'b11);
        mid();
        nxt();
        mid();
        chk("rw_req", 64'(sdram_req), 64'(1));
        sdram_ack = 1'b1;
        nxt();
        sdram_ack = 1'b0;
        mid();
        chk("rw_wait", 64'(sdram_req), 64'(0));
        rst     = 1'b1;
        slot_cs = '0;
        nxt();
        mid();
        chk("rw_rst_req", 64'(sdram_req), 64'(0));
        chk("rw_rst_ok", 64'(slot_ok), 64'(0));
        chk("rw_rst_dout", 64'(|slot_dout), 64'(0));
        nxt();
        rst       = 1'b0;
        data_rdy  = 1'b1;
        data_read = 32'hFFFFFFFF;
        nxt();
        data_rdy = 1'b0;
        mid();
        chk("rw_late_dout", 64'(|slot_dout), 64'(0));
        chk("rw_late_ok", 64'(slot_ok), 64'(0));
        chk("rw_late_req", 64'(sdram_req), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
